// File: rtl/reg_serial_reader.sv
// reg_serial_reader: captures a parallel word on request and sends it as start/data(LSB first)/[parity]/stop.
// Optional even parity bit when REG_SERIAL_PARITY_EN is defined.  Rev 1.0
`default_nettype none

module reg_serial_reader #(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             r_enable,
  input  logic [WIDTH-1:0] data_in,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef REG_SERIAL_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             div_last;
  logic             bit_last;
  logic             next_bit;
  logic             ser_nxt;
  logic             busy_nxt;
  logic             done_nxt;
`ifdef REG_SERIAL_PARITY_EN
  logic             parity_bit;
`endif

  assign div_last = (div_cnt == DIV_LAST);
  assign bit_last = (bit_cnt == BIT_LAST);

  // Bit that will sit in shift_reg[0] after the pending right shift.
  generate
    if (WIDTH > 1) begin : g_next_bit_wide
      assign next_bit = shift_reg[1];
    end else begin : g_next_bit_single
      assign next_bit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (r_enable) state_nxt = S_START;
      S_START: if (div_last) state_nxt = S_DATA;
      S_DATA: begin
        if (div_last && bit_last) begin
`ifdef REG_SERIAL_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_STOP;
`endif
        end
      end
`ifdef REG_SERIAL_PARITY_EN
      S_PARITY: if (div_last) state_nxt = S_STOP;
`endif
      S_STOP:  if (div_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered, so their next values track the state about to be entered.
  always_comb begin
    ser_nxt  = ser_out;
    busy_nxt = busy;
    done_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        ser_nxt  = 1'b1;
        busy_nxt = 1'b0;
        if (r_enable) begin
          ser_nxt  = 1'b0;
          busy_nxt = 1'b1;
        end
      end
      S_START: if (div_last) ser_nxt = shift_reg[0];
      S_DATA: begin
        if (div_last) begin
          if (bit_last) begin
`ifdef REG_SERIAL_PARITY_EN
            ser_nxt = parity_bit;
`else
            ser_nxt = 1'b1;
`endif
          end else begin
            ser_nxt = next_bit;
          end
        end
      end
`ifdef REG_SERIAL_PARITY_EN
      S_PARITY: if (div_last) ser_nxt = 1'b1;
`endif
      S_STOP: begin
        if (div_last) begin
          ser_nxt  = 1'b1;
          busy_nxt = 1'b0;
          done_nxt = 1'b1;
        end
      end
      default: begin
        ser_nxt  = 1'b1;
        busy_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ser_out <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      ser_out <= ser_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
`ifdef REG_SERIAL_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (state == S_IDLE) begin
      if (r_enable) begin
        shift_reg  <= data_in;
        bit_cnt    <= '0;
        div_cnt    <= '0;
`ifdef REG_SERIAL_PARITY_EN
        parity_bit <= ^data_in;
`endif
      end
    end else begin
      div_cnt <= div_last ? '0 : div_cnt + DIV_W'(1);
      if (state == S_DATA && div_last) begin
        shift_reg <= shift_reg >> 1;
        bit_cnt   <= bit_last ? '0 : bit_cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_serial_reader.sv
// Directed self-checking bench for reg_serial_reader (WIDTH=4 with DIV=1 and DIV=3).
`default_nettype none

module tb_reg_serial_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       r_en1 = 1'b0;
  logic [3:0] din1 = 4'd0;
  logic       ser1, busy1, done1;
  logic       r_en3 = 1'b0;
  logic [3:0] din3 = 4'd0;
  logic       ser3, busy3, done3;

  int checks = 0;
  int errors = 0;
  int frames1 = 0;
  int frames3 = 0;
  logic busy1_q = 1'b0;
  logic busy3_q = 1'b0;

  always #5 clk = ~clk;

  reg_serial_reader #(.WIDTH(4), .DIV(1)) dut1 (
    .clock(clk), .reset(rst), .r_enable(r_en1), .data_in(din1),
    .ser_out(ser1), .busy(busy1), .done(done1)
  );

  reg_serial_reader #(.WIDTH(4), .DIV(3)) dut3 (
    .clock(clk), .reset(rst), .r_enable(r_en3), .data_in(din3),
    .ser_out(ser3), .busy(busy3), .done(done3)
  );

  // Count frames by rising edges of busy.
  always @(negedge clk) begin
    busy1_q <= busy1;
    busy3_q <= busy3;
    if (busy1 && !busy1_q) frames1 <= frames1 + 1;
    if (busy3 && !busy3_q) frames3 <= frames3 + 1;
  end

`ifdef REG_SERIAL_PARITY_EN
  localparam int FLEN = 7;
  localparam logic [7:0] BITS_D1  = 8'b0110_0010;
  localparam logic [7:0] BITS_D14 = 8'b0111_1100;
  localparam logic [7:0] BITS_D5  = 8'b0100_1010;
`else
  localparam int FLEN = 6;
  localparam logic [7:0] BITS_D1  = 8'b0010_0010;
  localparam logic [7:0] BITS_D14 = 8'b0011_1100;
  localparam logic [7:0] BITS_D5  = 8'b0010_1010;
`endif

  typedef struct {
    logic [3:0] data;
    logic [7:0] bits;   // bits[k] = expected ser_out in frame cycle k
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic cur_ser(input int sel);
    return (sel == 3) ? ser3 : ser1;
  endfunction
  function automatic logic cur_busy(input int sel);
    return (sel == 3) ? busy3 : busy1;
  endfunction
  function automatic logic cur_done(input int sel);
    return (sel == 3) ? done3 : done1;
  endfunction

  // Called one step after the accepting edge; ends in the done cycle.
  task automatic check_frame(input int sel, input logic [7:0] bits, input int len,
                             input int div, input int poke);
    int c = 0;
    for (int k = 0; k < len; k++) begin
      for (int j = 0; j < div; j++) begin
        if (poke >= 0) begin
          if (c == poke) r_en1 = 1'b1;
          else if (c == poke + 1) r_en1 = 1'b0;
        end
        chk($sformatf("frame_ser dut%0d bit%0d", sel, k), cur_ser(sel), bits[k]);
        chk($sformatf("frame_busy dut%0d bit%0d", sel, k), cur_busy(sel), 1);
        chk($sformatf("frame_done dut%0d bit%0d", sel, k), cur_done(sel), 0);
        step();
        c++;
      end
    end
    chk($sformatf("end_busy dut%0d", sel), cur_busy(sel), 0);
    chk($sformatf("end_done dut%0d", sel), cur_done(sel), 1);
    chk($sformatf("end_ser dut%0d", sel), cur_ser(sel), 1);
  endtask

  initial begin
`ifdef REG_SERIAL_PARITY_EN
    vecs[0] = '{4'd3,  8'b0100_0110};
    vecs[1] = '{4'd12, 8'b0101_1000};
    vecs[2] = '{4'd14, 8'b0111_1100};
    vecs[3] = '{4'd0,  8'b0100_0000};
    vecs[4] = '{4'd15, 8'b0101_1110};
`else
    vecs[0] = '{4'd3,  8'b0010_0110};
    vecs[1] = '{4'd12, 8'b0011_1000};
    vecs[2] = '{4'd14, 8'b0011_1100};
    vecs[3] = '{4'd0,  8'b0010_0000};
    vecs[4] = '{4'd15, 8'b0011_1110};
`endif

    // Reset state
    repeat (3) step();
    chk("rst_ser1", ser1, 1);
    chk("rst_busy1", busy1, 0);
    chk("rst_done1", done1, 0);
    chk("rst_ser3", ser3, 1);
    chk("rst_busy3", busy3, 0);
    rst = 1'b0;
    step();
    chk("idle_ser1", ser1, 1);

    // Table of single frames; data_in is scrambled after capture
    for (int i = 0; i < 5; i++) begin
      din1 = vecs[i].data;
      r_en1 = 1'b1;
      step();
      r_en1 = 1'b0;
      din1 = ~vecs[i].data;
      check_frame(1, vecs[i].bits, FLEN, 1, -1);
      step();
      chk($sformatf("post_done vec%0d", i), done1, 0);
      chk($sformatf("post_ser vec%0d", i), ser1, 1);
    end

    // DIV=3: each level held three cycles
    din3 = 4'd5;
    r_en3 = 1'b1;
    step();
    r_en3 = 1'b0;
    check_frame(3, BITS_D5, FLEN, 3, -1);
    step();
    chk("div3_post_done", done3, 0);

    // Back-to-back with r_enable held; data_in changes mid-frame
    din1 = 4'd1;
    r_en1 = 1'b1;
    step();
    din1 = 4'd14;
    check_frame(1, BITS_D1, FLEN, 1, -1);
    step();
    r_en1 = 1'b0;
    check_frame(1, BITS_D14, FLEN, 1, -1);
    for (int i = 0; i < FLEN + 2; i++) begin
      step();
      chk("b2b_idle_ser", ser1, 1);
      chk("b2b_idle_busy", busy1, 0);
    end

    // Request while busy is ignored
    din1 = 4'd12;
    r_en1 = 1'b1;
    step();
    r_en1 = 1'b0;
    check_frame(1, vecs[1].bits, FLEN, 1, 2);
    for (int i = 0; i < FLEN + 2; i++) begin
      step();
      chk("ign_idle_ser", ser1, 1);
      chk("ign_idle_busy", busy1, 0);
      chk("ign_idle_done", done1, 0);
    end

    // Asynchronous reset mid-frame
    din1 = 4'd0;
    r_en1 = 1'b1;
    step();
    r_en1 = 1'b0;
    step();
    step();
    chk("pre_abort_ser", ser1, 0);
    chk("pre_abort_busy", busy1, 1);
    rst = 1'b1;
    #1;
    chk("abort_ser", ser1, 1);
    chk("abort_busy", busy1, 0);
    chk("abort_done", done1, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < FLEN + 2; i++) begin
      step();
      chk("post_abort_done", done1, 0);
      chk("post_abort_busy", busy1, 0);
      chk("post_abort_ser", ser1, 1);
    end

    step();
    chk("frame_count_dut1", frames1, 9);
    chk("frame_count_dut3", frames3, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
